multicycle_data_path: RTL and testbench

MULTICYCLE_DATA_PATH -- requirements
Module: multicycle_data_path

---
 rtl/multicycle_data_path.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_data_path.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_data_path.sv
// Multicycle RV32I-subset datapath: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Optional BEQ/BNE support is compiled in when the BRANCH_EN macro is defined.
module multicycle_data_path #(
    parameter int PC_W       = 8,
    parameter int DATA_W     = 32,
    parameter int RF_DEPTH   = 32,
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DM_ADDRESS-1:0] dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    output logic [DATA_W-1:0]     alu_result,
    output logic [2:0]            state,
    output logic                  retire
);
    localparam int         RIDX_W = $clog2(RF_DEPTH);
    localparam logic [5:0] RF_LIM = 6'(RF_DEPTH);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_retire;
    logic [PC_W-1:0]     r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_rs1;
    logic [DATA_W-1:0]   r_rs2;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_rf [RF_DEPTH];

    logic [6:0]          w_opcode;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1_idx;
    logic [4:0]          w_rs2_idx;
    logic [2:0]          w_funct3;
    logic                w_funct7b5;
    logic                w_is_r;
    logic                w_is_i;
    logic                w_is_ld;
    logic                w_is_st;
    logic                w_is_alu;
    logic                w_is_mem;
    logic                w_br_taken;
    logic [31:0]         w_imm32;
    logic [DATA_W-1:0]   w_imm_ext;
    logic [DATA_W-1:0]   w_rs1_data;
    logic [DATA_W-1:0]   w_rs2_data;
    logic [DATA_W-1:0]   w_op_b;
    logic [4:0]          w_shamt;
    logic [DATA_W-1:0]   w_alu;
    logic                w_wb_en;
    logic [DATA_W-1:0]   w_wb_data;
    logic [RF_DEPTH-1:0] w_rf_we;

    assign w_opcode   = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_funct3   = r_ir[14:12];
    assign w_rs1_idx  = r_ir[19:15];
    assign w_rs2_idx  = r_ir[24:20];
    assign w_funct7b5 = r_ir[30];
    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_is_ld    = (w_opcode == OP_LD);
    assign w_is_st    = (w_opcode == OP_ST);
    assign w_is_alu   = w_is_r || w_is_i;
    assign w_is_mem   = w_is_ld || w_is_st;

    always_comb begin
        case (w_opcode)
            OP_ST:   w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            OP_BR:   w_imm32 = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            default: w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
        endcase
    end
    assign w_imm_ext = DATA_W'($signed(w_imm32));

    // Index 0 and indices beyond the implemented file read as zero.
    assign w_rs1_data = (w_rs1_idx != 5'd0 && {1'b0, w_rs1_idx} < RF_LIM) ?
                        r_rf[w_rs1_idx[RIDX_W-1:0]] : '0;
    assign w_rs2_data = (w_rs2_idx != 5'd0 && {1'b0, w_rs2_idx} < RF_LIM) ?
                        r_rf[w_rs2_idx[RIDX_W-1:0]] : '0;

    assign w_op_b  = w_is_r ? r_rs2 : r_imm;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = '0;
        if (w_is_mem) begin
            w_alu = r_rs1 + r_imm;
        end else begin
            case (w_funct3)
                3'b000:  w_alu = (w_is_r && w_funct7b5) ? r_rs1 - w_op_b : r_rs1 + w_op_b;
                3'b001:  w_alu = r_rs1 << w_shamt;
                3'b010:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_rs1) < $signed(w_op_b))};
                3'b011:  w_alu = {{(DATA_W-1){1'b0}}, (r_rs1 < w_op_b)};
                3'b100:  w_alu = r_rs1 ^ w_op_b;
                3'b101:  w_alu = w_funct7b5 ? $unsigned($signed(r_rs1) >>> w_shamt) : r_rs1 >> w_shamt;
                3'b110:  w_alu = r_rs1 | w_op_b;
                default: w_alu = r_rs1 & w_op_b;
            endcase
        end
    end

`ifdef BRANCH_EN
    logic w_is_br;
    assign w_is_br    = (w_opcode == OP_BR) && (w_funct3[2:1] == 2'b00);
    assign w_br_taken = w_is_br && ((r_rs1 == r_rs2) ^ w_funct3[0]);
`else
    assign w_br_taken = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH:   if (imem_ready) w_state_next = S_DECODE;
            S_DECODE:  w_state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (w_is_alu) begin
                    w_state_next = S_WB;
                end else if (w_is_mem) begin
                    w_state_next = S_MEM;
                end else begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (w_is_st) begin
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_imm <= '0;
            r_alu <= '0;
            r_mdr <= '0;
        end else begin
            if (r_state == S_FETCH && imem_ready) r_ir <= imem_rdata;
            if (r_state == S_DECODE) begin
                r_rs1 <= w_rs1_data;
                r_rs2 <= w_rs2_data;
                r_imm <= w_imm_ext;
            end
            if (r_state == S_EXECUTE && (w_is_alu || w_is_mem)) r_alu <= w_alu;
            if (r_state == S_MEM && dmem_ready && !w_is_st) r_mdr <= dmem_rdata;
            if (w_retire) r_pc <= w_br_taken ? r_pc + r_imm[PC_W-1:0] : r_pc + PC_W'(4);
        end
    end

    assign w_wb_en   = (r_state == S_WB);
    assign w_wb_data = w_is_ld ? r_mdr : r_alu;

    // Row 0 has no write enable, so x0 stays zero.
    for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_rf_we
        if (gi == 0) begin : g_zero
            assign w_rf_we[gi] = 1'b0;
        end else begin : g_row
            assign w_rf_we[gi] = w_wb_en && (w_rd == 5'(gi));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
        end else begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                if (w_rf_we[i]) r_rf[i] <= w_wb_data;
            end
        end
    end

    assign imem_req   = (r_state == S_FETCH) && !reset;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = dmem_req && w_is_st;
    assign dmem_addr  = r_alu[DM_ADDRESS-1:0];
    assign dmem_wdata = r_rs2;
    assign alu_result = r_alu;
    assign state      = r_state;
    assign retire     = w_retire;
endmodule

// File: tb/tb_multicycle_data_path.sv
// Scoreboard bench for multicycle_data_path: expected retirements are queued by the
// stimulus process and checked by a monitor on every retire pulse.
module tb_multicycle_data_path;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [8:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] alu_result;
    logic [2:0]  state;
    logic        retire;

    multicycle_data_path #(
        .PC_W(8), .DATA_W(32), .RF_DEPTH(16), .DM_ADDRESS(9)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .alu_result(alu_result), .state(state), .retire(retire)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    typedef struct {
        logic [7:0]  pc;
        int          lat;
        bit          ca;
        logic [31:0] alu;
        bit          cm;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog [64];
    logic [31:0] dmem_mem [512];
    int          dmem_wait;
    int          total = 0;
    int          bad = 0;
    int          n_retired = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic push(input logic [7:0] pc, input int lat, input bit ca, input logic [31:0] alu,
                        input bit cm, input bit we, input logic [8:0] addr, input logic [31:0] wd);
        exp_t e;
        e.pc = pc; e.lat = lat; e.ca = ca; e.alu = alu; e.cm = cm; e.we = we; e.addr = addr; e.wd = wd;
        sb.push_back(e);
    endtask
    task automatic exp_alu(input logic [7:0] pc, input logic [31:0] alu);
        push(pc, 4, 1'b1, alu, 1'b0, 1'b0, 9'd0, 32'd0);
    endtask
    task automatic exp_nop(input logic [7:0] pc);
        push(pc, 3, 1'b0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("imem_req after reset release", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic wait_retires(input int target);
        int cnt = 0;
        while (n_retired < target && cnt < 2000) begin
            @(negedge clk);
            #1 cnt++;
        end
        chk("retire count before timeout", n_retired, target);
        chk("scoreboard drained", sb.size(), 32'd0);
    endtask

    // Memory responder: zero-wait instruction memory, data memory with dmem_wait wait cycles.
    initial begin
        int dcnt;
        dcnt = 0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                imem_ready = 1'b0;
                dmem_ready = 1'b0;
                dcnt = 0;
            end else begin
                imem_ready = imem_req;
                if (imem_req) imem_rdata = prog[imem_addr[7:2]];
                if (dmem_req) begin
                    if (dcnt >= dmem_wait) begin
                        dmem_ready = 1'b1;
                        dcnt = 0;
                        if (dmem_we) dmem_mem[dmem_addr] = dmem_wdata;
                        else         dmem_rdata = dmem_mem[dmem_addr];
                    end else begin
                        dmem_ready = 1'b0;
                        dcnt++;
                    end
                end else begin
                    dmem_ready = 1'b0;
                    dcnt = 0;
                end
            end
        end
    end

    // Monitor: counts cycles per instruction and checks each retirement against the scoreboard.
    initial begin
        int          cyc;
        bit          mem_seen;
        logic        m_we;
        logic [8:0]  m_addr;
        logic [31:0] m_wd;
        logic [7:0]  cur_pc;
        exp_t        e;
        cyc = 0; mem_seen = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; cur_pc = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0;
                mem_seen = 1'b0;
            end else begin
                cyc++;
                if (imem_req) cur_pc = imem_addr;
                if (dmem_req) begin
                    mem_seen = 1'b1;
                    m_we = dmem_we; m_addr = dmem_addr; m_wd = dmem_wdata;
                end
                if (retire) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected retire: got pc %h want no retire", cur_pc);
                    end else begin
                        e = sb.pop_front();
                        $display("retire pc=%h lat=%0d alu=%h mem=%0d", cur_pc, cyc, alu_result, mem_seen);
                        chk("fetch pc", {24'd0, cur_pc}, {24'd0, e.pc});
                        chk("latency", cyc, e.lat);
                        if (e.ca) chk("alu_result", alu_result, e.alu);
                        chk("dmem access seen", {31'd0, mem_seen}, {31'd0, e.cm});
                        if (e.cm && mem_seen) begin
                            chk("dmem_we", {31'd0, m_we}, {31'd0, e.we});
                            chk("dmem_addr", {23'd0, m_addr}, {23'd0, e.addr});
                            if (e.we) chk("dmem_wdata", m_wd, e.wd);
                        end
                    end
                    n_retired++;
                    cyc = 0;
                    mem_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        reset = 1'b0;
        dmem_wait = 0;
        clear_prog();
        #1 reset = 1'b1;
        #2;
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("reset retire", {31'd0, retire}, 32'd0);
        chk("reset pc", {24'd0, imem_addr}, 32'd0);
        chk("reset alu_result", alu_result, 32'd0);

        // Phase A: ALU ops, x0/x20 discard, store/load with 2 wait cycles.
        prog[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_I);
        prog[1]  = enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2);
        prog[2]  = enc_s(12'd8, 5'd2, 5'd0);
        prog[3]  = enc_i(12'd8, 5'd0, 3'b010, 5'd3, OP_LD);
        prog[4]  = enc_r(7'd0, 5'd0, 5'd3, 3'b000, 5'd4);
        prog[5]  = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_I);
        prog[6]  = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd5);
        prog[7]  = enc_i(12'd1, 5'd0, 3'b000, 5'd20, OP_I);
        prog[8]  = enc_r(7'd0, 5'd0, 5'd20, 3'b000, 5'd6);
        prog[9]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7);
        prog[10] = enc_r(7'b0100000, 5'd1, 5'd7, 3'b101, 5'd8);
        prog[11] = enc_r(7'd0, 5'd1, 5'd7, 3'b101, 5'd9);
        prog[12] = enc_r(7'd0, 5'd7, 5'd1, 3'b011, 5'd10);
        prog[13] = enc_r(7'd0, 5'd7, 5'd1, 3'b010, 5'd11);
        prog[14] = enc_i(12'hFFF, 5'd1, 3'b100, 5'd12, OP_I);
        prog[15] = enc_i(12'h004, 5'd1, 3'b001, 5'd13, OP_I);
        prog[16] = enc_i(12'h401, 5'd7, 3'b101, 5'd14, OP_I);
        prog[17] = enc_i(12'h0F0, 5'd7, 3'b111, 5'd15, OP_I);
        prog[18] = enc_s(12'd12, 5'd4, 5'd1);
        dmem_wait = 2;
        exp_alu(8'h00, 32'd5);
        exp_alu(8'h04, 32'd10);
        push(8'h08, 6, 1'b1, 32'd8, 1'b1, 1'b1, 9'd8, 32'd10);
        push(8'h0C, 7, 1'b1, 32'd8, 1'b1, 1'b0, 9'd8, 32'd0);
        exp_alu(8'h10, 32'd10);
        exp_alu(8'h14, 32'd7);
        exp_alu(8'h18, 32'd0);
        exp_alu(8'h1C, 32'd1);
        exp_alu(8'h20, 32'd0);
        exp_alu(8'h24, 32'hFFFF_FFFB);
        exp_alu(8'h28, 32'hFFFF_FFFF);
        exp_alu(8'h2C, 32'h07FF_FFFF);
        exp_alu(8'h30, 32'd1);
        exp_alu(8'h34, 32'd0);
        exp_alu(8'h38, 32'hFFFF_FFFA);
        exp_alu(8'h3C, 32'h0000_0050);
        exp_alu(8'h40, 32'hFFFF_FFFD);
        exp_alu(8'h44, 32'h0000_00F0);
        push(8'h48, 6, 1'b1, 32'd17, 1'b1, 1'b1, 9'd17, 32'd10);
        tgt = n_retired + 19;
        apply_reset();
        wait_retires(tgt);

        // Phase B: NOPs and BEQ x1,x1,-8 at 0x10.
        clear_prog();
        dmem_wait = 0;
        prog[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, OP_I);
        prog[2] = enc_i(12'd9, 5'd0, 3'b000, 5'd5, OP_I);
        prog[4] = enc_b(13'h1FF8, 5'd1, 5'd1, 3'b000);
        prog[5] = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OP_I);
        exp_alu(8'h00, 32'd3);
        exp_nop(8'h04);
        exp_alu(8'h08, 32'd9);
        exp_nop(8'h0C);
        exp_nop(8'h10);
`ifdef BRANCH_EN
        exp_alu(8'h08, 32'd9);
`else
        exp_alu(8'h14, 32'd1);
`endif
        tgt = n_retired + 6;
        apply_reset();
        wait_retires(tgt);

        // Phase C: reset while a store is stalled in MEM.
        clear_prog();
        prog[0] = enc_s(12'd0, 5'd0, 5'd0);
        dmem_wait = 10;
        apply_reset();
        begin
            int cnt = 0;
            while (dmem_req !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
        end
        chk("dmem_req raised before reset", {31'd0, dmem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid-MEM reset dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("mid-MEM reset state", {29'd0, state}, 32'd0);
        chk("mid-MEM reset pc", {24'd0, imem_addr}, 32'd0);
        chk("mid-MEM reset retire", {31'd0, retire}, 32'd0);
        chk("mid-MEM reset imem_req", {31'd0, imem_req}, 32'd0);
        repeat (3) @(posedge clk);

        // Phase D: zero-wait store/load then NOPs up to 0xFC, wrapping to 0x00.
        clear_prog();
        dmem_wait = 0;
        prog[0] = enc_s(12'd0, 5'd0, 5'd0);
        prog[1] = enc_i(12'd0, 5'd0, 3'b010, 5'd1, OP_LD);
        push(8'h00, 4, 1'b1, 32'd0, 1'b1, 1'b1, 9'd0, 32'd0);
        push(8'h04, 5, 1'b1, 32'd0, 1'b1, 1'b0, 9'd0, 32'd0);
        for (int i = 2; i < 64; i++) exp_nop(8'(i * 4));
        push(8'h00, 4, 1'b1, 32'd0, 1'b1, 1'b1, 9'd0, 32'd0);
        tgt = n_retired + 65;
        apply_reset();
        wait_retires(tgt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
